// File: rtl/sequencer_mc.sv
// Multi-channel FPC command sequencer: decodes an inline command stream from a
// first-word-fall-through FIFO and routes payload bursts to addressed channels.
module sequencer_mc #(
    parameter int DW  = 64,
    parameter int NCH = 16,
    parameter int AW  = 8,
    parameter int CW  = 32
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    output logic           fpc_read_o,
    input  logic           fpc_valid_i,
    input  logic [DW-1:0]  fpc_data_i,
    output logic [DW-1:0]  data_o,
    output logic           c_valid_o,
    output logic [AW-1:0]  d_addr_o,
    output logic           d_valid_o,
    input  logic [NCH-1:0] d_ready_i,
    input  logic [NCH-1:0] flag_i,
    input  logic           err_clear_i,
    output logic           busy_o,
    output logic [2:0]     error_o
);

    localparam logic [1:0] S_CMD       = 2'd0;
    localparam logic [1:0] S_WAIT_CYC  = 2'd1;
    localparam logic [1:0] S_WRITE     = 2'd2;
    localparam logic [1:0] S_WAIT_FLAG = 2'd3;
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] ch_q, ch_d;
    logic          drop_q, drop_d;
    logic [DW-1:0] data_q, data_d;
    logic          c_valid_q, c_valid_d;
    logic          d_valid_q, d_valid_d;
    logic [AW-1:0] d_addr_q, d_addr_d;
    logic [2:0]    error_q, error_d;
    logic          busy_q, busy_d;

    logic [3:0]    op;
    logic [AW-1:0] ch_in;
    logic [CW-1:0] n_in;
    logic          ch_in_bad;
    logic [IW-1:0] ch_idx;
    logic          ready_sel;
    logic          flag_sel;
    logic          decode_en;
    logic [2:0]    err_set;

    assign op        = fpc_data_i[DW-1:DW-4];
    assign ch_in     = fpc_data_i[DW-5:DW-4-AW];
    assign n_in      = fpc_data_i[CW-1:0];
    assign ch_in_bad = (32'(ch_in) >= 32'(NCH));
    assign ch_idx    = ch_q[IW-1:0];
    assign ready_sel = d_ready_i[ch_idx];
    assign flag_sel  = flag_i[ch_idx];

    // Pop is purely combinational so a FWFT head word is consumed in the cycle it is accepted.
    always_comb begin
        fpc_read_o = 1'b0;
        if (rst_ni) begin
            case (state_q)
                S_CMD:       fpc_read_o = fpc_valid_i;
                S_WRITE:     fpc_read_o = fpc_valid_i && (drop_q || ready_sel);
                S_WAIT_FLAG: fpc_read_o = fpc_valid_i && flag_sel;
                default:     fpc_read_o = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        ch_d      = ch_q;
        drop_d    = drop_q;
        data_d    = data_q;
        c_valid_d = 1'b0;
        d_valid_d = 1'b0;
        d_addr_d  = d_addr_q;
        err_set   = 3'b000;
        decode_en = 1'b0;

        if (fpc_read_o) data_d = fpc_data_i;

        case (state_q)
            S_CMD: decode_en = fpc_read_o;
            S_WAIT_CYC: begin
                if (count_q != '0) count_d = count_q - CW'(1);
                if (count_q <= CW'(1)) state_d = S_CMD;
            end
            S_WRITE: begin
                if (fpc_read_o) begin
                    d_valid_d = !drop_q;
                    if (!drop_q) d_addr_d = ch_q;
                    if (count_q != '0) count_d = count_q - CW'(1);
                    if (count_q <= CW'(1)) state_d = S_CMD;
                end
            end
            default: begin
                // A flag hit behaves like CMD: the next command is taken in the same cycle.
                if (flag_sel) begin
                    state_d   = S_CMD;
                    decode_en = fpc_read_o;
                end else if (count_q != '0) begin
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_d    = S_CMD;
                        err_set[2] = 1'b1;
                    end
                end
            end
        endcase

        if (decode_en) begin
            state_d = S_CMD;
            case (op)
                4'd0: c_valid_d = 1'b1;
                4'd1: begin
                    if (n_in != '0) begin
                        state_d = S_WAIT_CYC;
                        count_d = n_in;
                    end
                end
                4'd2: begin
                    err_set[1] = ch_in_bad;
                    if (n_in != '0) begin
                        state_d = S_WRITE;
                        count_d = n_in;
                        ch_d    = ch_in;
                        drop_d  = ch_in_bad;
                    end
                end
                4'd3: begin
                    if (ch_in_bad) begin
                        err_set[1] = 1'b1;
                    end else begin
                        state_d = S_WAIT_FLAG;
                        count_d = n_in;
                        ch_d    = ch_in;
                    end
                end
                default: err_set[0] = 1'b1;
            endcase
        end

        error_d = (err_clear_i ? 3'b000 : error_q) | err_set;
        busy_d  = (state_d != S_CMD);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_CMD;
            count_q   <= '0;
            ch_q      <= '0;
            drop_q    <= 1'b0;
            data_q    <= '0;
            c_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            d_addr_q  <= '0;
            error_q   <= 3'b000;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            ch_q      <= ch_d;
            drop_q    <= drop_d;
            data_q    <= data_d;
            c_valid_q <= c_valid_d;
            d_valid_q <= d_valid_d;
            d_addr_q  <= d_addr_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
        end
    end

    assign data_o    = data_q;
    assign c_valid_o = c_valid_q;
    assign d_valid_o = d_valid_q;
    assign d_addr_o  = d_addr_q;
    assign error_o   = error_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_sequencer_mc.sv
// Bench for sequencer_mc: a FIFO model feeds command streams, a scoreboard queue
// holds the expected c_valid/d_valid transactions in order.
module tb_sequencer_mc;

    logic        clk;
    logic        rst_n;
    logic        fpc_read_o;
    logic        fpc_valid_i;
    logic [63:0] fpc_data_i;
    logic [63:0] data_o;
    logic        c_valid_o;
    logic [7:0]  d_addr_o;
    logic        d_valid_o;
    logic [15:0] d_ready_i;
    logic [15:0] flag_i;
    logic        err_clear_i;
    logic        busy_o;
    logic [2:0]  error_o;

    sequencer_mc #(.DW(64), .NCH(16), .AW(8), .CW(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .fpc_read_o  (fpc_read_o),
        .fpc_valid_i (fpc_valid_i),
        .fpc_data_i  (fpc_data_i),
        .data_o      (data_o),
        .c_valid_o   (c_valid_o),
        .d_addr_o    (d_addr_o),
        .d_valid_o   (d_valid_o),
        .d_ready_i   (d_ready_i),
        .flag_i      (flag_i),
        .err_clear_i (err_clear_i),
        .busy_o      (busy_o),
        .error_o     (error_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          kind;   // 0 none, 1 ctrl, 2 data
        logic [7:0]  addr;
        logic [63:0] data;
    } exp_t;

    typedef struct {
        logic [63:0] word;
        int          kind;
        logic [7:0]  addr;
    } vec_t;

    logic [63:0] fifo[$];
    exp_t        exp_q[$];
    int n_checks = 0, n_pass = 0;
    int cyc = 0, pop_cnt, low_cnt, busy_cnt, cv_cnt, dv_cnt, viol, cv_last_cyc, cv_gap;
    logic wr_chk = 1'b0;

    function automatic logic [63:0] mk(input logic [3:0] op, input logic [7:0] ch, input logic [31:0] n);
        return {op, ch, 20'd0, n};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic refresh();
        fpc_valid_i = (fifo.size() != 0);
        fpc_data_i  = (fifo.size() != 0) ? fifo[0] : 64'd0;
    endtask

    task automatic push(input logic [63:0] w);
        fifo.push_back(w);
        refresh();
    endtask

    task automatic expect_out(input int kind, input logic [7:0] addr, input logic [63:0] data);
        exp_t e;
        e.kind = kind; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic reset_stats();
        pop_cnt = 0; low_cnt = 0; busy_cnt = 0; cv_cnt = 0; dv_cnt = 0; viol = 0;
        cv_last_cyc = cyc; cv_gap = 0;
    endtask

    // One clock: sample and score at negedge, then advance the FIFO after the posedge.
    task automatic tick();
        logic pop;
        int   kind;
        exp_t e;
        @(negedge clk);
        cyc++;
        pop = rst_n && fpc_read_o && fpc_valid_i;
        if (pop) pop_cnt++;
        if (rst_n && fpc_valid_i && !fpc_read_o) low_cnt++;
        if (busy_o) busy_cnt++;
        if (wr_chk && fpc_read_o && busy_o && !d_ready_i[2]) viol++;
        check("c_d_exclusive", 64'(c_valid_o & d_valid_o), 64'd0);
        if (c_valid_o || d_valid_o) begin
            kind = c_valid_o ? 1 : 2;
            if (c_valid_o) begin
                cv_cnt++;
                cv_gap = cyc - cv_last_cyc;
                cv_last_cyc = cyc;
            end
            if (d_valid_o) dv_cnt++;
            $display("txn %s addr=%0d data=%016h", c_valid_o ? "ctrl" : "data", d_addr_o, data_o);
            if (exp_q.size() == 0) begin
                check("sb_unexpected", 64'(kind), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_kind", 64'(kind), 64'(e.kind));
                check("sb_data", data_o, e.data);
                if (kind == 2) check("sb_addr", 64'(d_addr_o), 64'(e.addr));
            end
        end
        @(posedge clk);
        #1;
        if (pop) void'(fifo.pop_front());
        refresh();
    endtask

    task automatic run_until_idle(input int bound);
        int n = 0;
        while ((fifo.size() != 0 || busy_o || exp_q.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        check("idle_timeout", 64'(n >= bound), 64'd0);
        check("sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic clear_errors();
        err_clear_i = 1'b1;
        tick();
        err_clear_i = 1'b0;
    endtask

    initial begin
        vec_t        tbl[12];
        logic [0:5]  pat;
        int          k, n;

        rst_n = 1'b0; d_ready_i = '1; flag_i = '0; err_clear_i = 1'b0;
        refresh();
        reset_stats();

        // Reset state, then CTRL / WAIT_CYC 3 / CTRL timing.
        push(mk(4'h0, 8'd0, 32'h1234)); expect_out(1, 0, 64'h1234);
        push(mk(4'h1, 8'd0, 32'd3));
        push(mk(4'h0, 8'd0, 32'h5678)); expect_out(1, 0, 64'h5678);
        #12;
        check("rst_fpc_read", 64'(fpc_read_o), 64'd0);
        check("rst_outputs", {data_o[55:0], c_valid_o, d_valid_o, busy_o, error_o, 2'b00}, 64'd0);
        check("rst_d_addr", 64'(d_addr_o), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        reset_stats();
        run_until_idle(40);
        check("wc_cv_count", 64'(cv_cnt), 64'd2);
        check("wc_cv_gap", 64'(cv_gap), 64'd5);
        check("wc_read_low", 64'(low_cnt), 64'd3);

        // Mixed stream from a table, all channels ready.
        tbl[0]  = '{mk(4'h0, 8'd0,  32'hA1), 1, 8'd0};
        tbl[1]  = '{mk(4'h2, 8'd1,  32'd2),  0, 8'd0};
        tbl[2]  = '{64'h1111_2222_3333_4444, 2, 8'd1};
        tbl[3]  = '{64'h3000_0000_0000_0005, 2, 8'd1};
        tbl[4]  = '{mk(4'h1, 8'd0,  32'd2),  0, 8'd0};
        tbl[5]  = '{mk(4'h0, 8'd0,  32'hA2), 1, 8'd0};
        tbl[6]  = '{mk(4'h2, 8'd15, 32'd1),  0, 8'd0};
        tbl[7]  = '{64'hF0F0_0000_0000_00AB, 2, 8'd15};
        tbl[8]  = '{mk(4'h3, 8'd0,  32'd0),  0, 8'd0};
        tbl[9]  = '{mk(4'h0, 8'd0,  32'hA3), 1, 8'd0};
        tbl[10] = '{mk(4'h2, 8'd0,  32'd0),  0, 8'd0};
        tbl[11] = '{mk(4'h0, 8'd0,  32'hA4), 1, 8'd0};
        flag_i = 16'h0001;
        reset_stats();
        for (int i = 0; i < 12; i++) begin
            push(tbl[i].word);
            if (tbl[i].kind != 0) expect_out(tbl[i].kind, tbl[i].addr, tbl[i].word);
        end
        run_until_idle(80);
        flag_i = '0;
        check("tbl_dv_count", 64'(dv_cnt), 64'd3);
        check("tbl_error", 64'(error_o), 64'd0);

        // WRITE ch=2 N=4 with d_ready[2] toggling 1,0,1,1,0,1.
        pat = 6'b101101;
        reset_stats();
        wr_chk = 1'b1;
        push(mk(4'h2, 8'd2, 32'd4));
        push(64'hF000_0000_0000_0001); expect_out(2, 8'd2, 64'hF000_0000_0000_0001);
        push(64'h1000_0000_0000_0002); expect_out(2, 8'd2, 64'h1000_0000_0000_0002);
        push(64'h3000_0000_0000_0003); expect_out(2, 8'd2, 64'h3000_0000_0000_0003);
        push(64'h2000_0000_0000_0004); expect_out(2, 8'd2, 64'h2000_0000_0000_0004);
        push(mk(4'h0, 8'd0, 32'hC2));  expect_out(1, 8'd0, mk(4'h0, 8'd0, 32'hC2));
        k = 0; n = 0;
        while ((fifo.size() != 0 || busy_o || exp_q.size() != 0) && n < 60) begin
            if (busy_o && k < 6) begin
                d_ready_i[2] = pat[k];
                k++;
            end else begin
                d_ready_i[2] = 1'b1;
            end
            tick();
            n++;
        end
        wr_chk = 1'b0;
        check("wr_timeout", 64'(n >= 60), 64'd0);
        check("wr_sb_empty", 64'(exp_q.size()), 64'd0);
        check("wr_cycles", 64'(k), 64'd6);
        check("wr_pop_not_ready", 64'(viol), 64'd0);
        check("wr_dv_count", 64'(dv_cnt), 64'd4);
        check("wr_error", 64'(error_o), 64'd0);

        // WRITE to a nonexistent channel drops payload regardless of d_ready.
        d_ready_i = '0;
        reset_stats();
        push(mk(4'h2, 8'd20, 32'd2));
        push(mk(4'h0, 8'd0, 32'hAAA));
        push(mk(4'h0, 8'd0, 32'hBBB));
        push(mk(4'h0, 8'd0, 32'hC3)); expect_out(1, 8'd0, mk(4'h0, 8'd0, 32'hC3));
        run_until_idle(40);
        d_ready_i = '1;
        check("badch_dv_count", 64'(dv_cnt), 64'd0);
        check("badch_error", 64'(error_o), 64'd2);
        clear_errors();
        check("badch_cleared", 64'(error_o), 64'd0);

        // WAIT_FLAG ch=5 without timeout, flag arrives after 10 cycles.
        reset_stats();
        push(mk(4'h3, 8'd5, 32'd0));
        push(mk(4'h0, 8'd0, 32'hF1)); expect_out(1, 8'd0, mk(4'h0, 8'd0, 32'hF1));
        tick();
        for (int i = 0; i < 10; i++) tick();
        check("wf_no_pop", 64'(pop_cnt), 64'd1);
        check("wf_busy", 64'(busy_o), 64'd1);
        flag_i[5] = 1'b1;
        tick();
        flag_i[5] = 1'b0;
        check("wf_pop_on_flag", 64'(pop_cnt), 64'd2);
        run_until_idle(20);

        // WAIT_FLAG ch=5 N=7 with flag low times out.
        push(mk(4'h3, 8'd5, 32'd7));
        push(mk(4'h0, 8'd0, 32'hF2)); expect_out(1, 8'd0, mk(4'h0, 8'd0, 32'hF2));
        tick();
        n = 0;
        while (!error_o[2] && n < 20) begin
            tick();
            n++;
        end
        check("wf_timeout_cycles", 64'(n), 64'd7);
        check("wf_timeout_busy", 64'(busy_o), 64'd0);
        run_until_idle(20);
        check("wf_timeout_error", 64'(error_o), 64'd4);
        clear_errors();

        // Bad opcode popped while err_clear is high: set wins. Then zero-length WRITE.
        err_clear_i = 1'b1;
        push(mk(4'hF, 8'd0, 32'd1));
        tick();
        err_clear_i = 1'b0;
        check("badop_set_priority", 64'(error_o), 64'd1);
        reset_stats();
        push(mk(4'h2, 8'd1, 32'd0));
        push(mk(4'h0, 8'd0, 32'h77)); expect_out(1, 8'd0, mk(4'h0, 8'd0, 32'h77));
        run_until_idle(20);
        check("w0_busy", 64'(busy_cnt), 64'd0);
        check("w0_dv_count", 64'(dv_cnt), 64'd0);
        check("w0_error", 64'(error_o), 64'd1);
        clear_errors();

        // Reset in the middle of WRITE ch=3 N=8 after 3 payload words.
        reset_stats();
        push(mk(4'h2, 8'd3, 32'd8));
        for (int i = 1; i <= 3; i++) begin
            push(mk(4'hE, 8'd0, 32'(i)));
            expect_out(2, 8'd3, mk(4'hE, 8'd0, 32'(i)));
        end
        for (int i = 4; i <= 8; i++) begin
            push(mk(4'h0, 8'd0, 32'h40 + 32'(i)));
            expect_out(1, 8'd0, mk(4'h0, 8'd0, 32'h40 + 32'(i)));
        end
        n = 0;
        while (pop_cnt < 4 && n < 20) begin
            tick();
            n++;
        end
        d_ready_i[3] = 1'b0;
        tick();
        check("mid_dv_count", 64'(dv_cnt), 64'd3);
        check("mid_pop_count", 64'(pop_cnt), 64'd4);
        check("mid_busy", 64'(busy_o), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", {data_o[55:0], c_valid_o, d_valid_o, busy_o, error_o, fpc_read_o, 1'b0}, 64'd0);
        check("mid_rst_d_addr", 64'(d_addr_o), 64'd0);
        tick();
        rst_n = 1'b1;
        d_ready_i = '1;
        run_until_idle(40);
        check("mid_cv_count", 64'(cv_cnt), 64'd5);
        check("mid_error", 64'(error_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
